lfsr_stream_checker: RTL and testbench
======================================

LFSR_STREAM_CHECKER -- requirements
Module: lfsr_stream_checker

Interface
REQ-001 SHALL have parameter LOCK_MATCHES, default 4: number of consecutive matches needed to assert locked.
REQ-002 SHALL have parameter MISS_LIMIT, default 3: number of consecutive mismatches while locked that drops lock.
REQ-003 SHALL have port clock  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port word_valid  input  1  qualifies word_in for one cycle.
REQ-006 SHALL have port word_in  input  32  received PRNG word.
REQ-007 SHALL have port word_ready  output  1  high in states SEED and WAIT.
REQ-008 SHALL have port locked  output  1  stream verified.
REQ-009 SHALL have port match_pulse  output  1  one-cycle pulse per compared word that equals the prediction.
REQ-010 SHALL have port err_pulse  output  1  one-cycle pulse per compared word that differs from the prediction.
REQ-011 SHALL have port overrun_pulse  output  1  one-cycle pulse when word_valid arrives in state ADVANCE.
REQ-012 SHALL have port err_count  output  16  mismatches counted while locked; saturates at 0xFFFF.
REQ-013 SHALL have port word_count  output  16  accepted words; saturates at 0xFFFF.
REQ-014 SHALL have port pred  output  32  current predicted LFSR state.

Function
REQ-015 step(s) SHALL be {s[31]^s[21]^s[1]^s[0], s[31:1]}: a right shift with the feedback bit entering bit 31.
REQ-016 Consecutive words of a valid stream SHALL be exactly 32 steps apart; the checker predicts each next word as step applied 32 times to the previous one.
REQ-017 The FSM SHALL have exactly three states: SEED (no reference word), ADVANCE (stepping pred), and WAIT (prediction ready).
REQ-018 A word is accepted on an edge where word_valid is high and the FSM is in SEED or WAIT; word_count then increments.
REQ-019 In SEED, a nonzero accepted word SHALL load pred <= step(word_in) and set the advance counter to 31; the FSM then goes to ADVANCE with no match or error pulse.
REQ-020 In SEED, word_in == 0 SHALL be counted in word_count and is otherwise ignored; the FSM stays in SEED.
REQ-021 In ADVANCE, each edge SHALL apply pred <= step(pred) and decrement the counter; after the 31st ADVANCE edge the FSM goes to WAIT (32 steps total).
REQ-022 word_valid in ADVANCE SHALL pulse overrun_pulse and leave all other state, counters and the word unchanged.
REQ-023 In WAIT, an accepted word is compared against pred: equal pulses match_pulse; different pulses err_pulse.
REQ-024 On a match, the match run counter SHALL increment and the miss counter SHALL clear; locked sets on the edge the run counter reaches LOCK_MATCHES.
REQ-025 On a mismatch while unlocked, the run counter SHALL clear and the checker reseeds from word_in as in REQ-019; a zero word_in returns the FSM to SEED.
REQ-026 On a mismatch while locked, err_count SHALL increment and the miss counter SHALL increment; the checker flywheels: pred <= step(pred), counter 31, go to ADVANCE.
REQ-027 When the miss counter reaches MISS_LIMIT while locked, locked SHALL clear, the run counter SHALL clear, and the checker reseeds from word_in (per REQ-025) on that same edge.
REQ-028 On a match, the checker SHALL reseed from word_in (identical to pred) and go to ADVANCE.
REQ-029 Pulse outputs SHALL be registered, high for exactly the cycle after the accepting edge.
REQ-030 Back-to-back words spaced 32 cycles apart SHALL never overrun: an accept at edge k lands in WAIT from edge k+31.

Reset
REQ-031 Reset asserted SHALL immediately force: state SEED, pred 0, counters 0, locked 0, all pulses 0, err_count 0, word_count 0.
REQ-032 Reset mid-ADVANCE or while locked SHALL discard all history; the first nonzero word after release reseeds.

Verification
REQ-033 Reset; word 0x0000000D accepted -> next cycle pred = 0x80000006, word_ready = 0 for 31 cycles, word_count = 1.
REQ-034 Model-generated stream of 6 words from seed 13, 32 cycles apart -> 5 match pulses, locked rises with the 4th match, err_count = 0, no overrun.
REQ-035 While locked, corrupt one word (bit 0 flipped) -> err_pulse, err_count = 1, still locked; the following true word matches via the flywheel.
REQ-036 While locked, inject 3 consecutive wrong words -> locked falls on the 3rd, err_count = 3, checker reseeds from the 3rd word.
REQ-037 Word_valid 10 cycles after an accept -> overrun_pulse, word_count unchanged; word 0 in SEED -> state stays SEED.
REQ-038 Assert reset mid-ADVANCE while locked -> all outputs 0 asynchronously, word_ready = 1 after release.

Source files
------------

// File: rtl/lfsr_stream_checker.sv
// Checks a received stream of 32-bit PRNG words. Each word must be the previous word
// advanced 32 LFSR steps. Lock is gained after a run of matches and lost after repeated misses.
module lfsr_stream_checker #(
  parameter int LOCK_MATCHES = 4,
  parameter int MISS_LIMIT   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        word_valid,
  input  logic [31:0] word_in,
  output logic        word_ready,
  output logic        locked,
  output logic        match_pulse,
  output logic        err_pulse,
  output logic        overrun_pulse,
  output logic [15:0] err_count,
  output logic [15:0] word_count,
  output logic [31:0] pred
);

  localparam int RUN_W  = $clog2(LOCK_MATCHES + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {
    SEED    = 2'd0,
    ADVANCE = 2'd1,
    WAIT    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pred_q, pred_d;
  logic [4:0]        adv_cnt_q, adv_cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
  logic              locked_q, locked_d;
  logic              match_q, match_d;
  logic              err_q, err_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              accept;

  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[31] ^ s[21] ^ s[1] ^ s[0], s[31:1]};
  endfunction

  assign word_ready = (state_q == SEED) || (state_q == WAIT);
  assign accept     = word_valid && word_ready;
  assign miss_inc   = miss_q + MISS_W'(1);

  always_comb begin
    state_d      = state_q;
    pred_d       = pred_q;
    adv_cnt_d    = adv_cnt_q;
    run_d        = run_q;
    miss_d       = miss_q;
    locked_d     = locked_q;
    match_d      = 1'b0;
    err_d        = 1'b0;
    overrun_d    = 1'b0;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;

    if (accept && (word_count_q != 16'hFFFF)) begin
      word_count_d = word_count_q + 16'd1;
    end

    case (state_q)
      SEED: begin
        if (accept && (word_in != 32'd0)) begin
          pred_d    = step(word_in);
          adv_cnt_d = 5'd31;
          state_d   = ADVANCE;
        end
      end

      ADVANCE: begin
        pred_d    = step(pred_q);
        adv_cnt_d = adv_cnt_q - 5'd1;
        overrun_d = word_valid;
        if (adv_cnt_q == 5'd1) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (accept) begin
          // Every path out of an accepted word reseeds unless a locked miss flywheels.
          if (word_in != 32'd0) begin
            pred_d    = step(word_in);
            adv_cnt_d = 5'd31;
            state_d   = ADVANCE;
          end else begin
            state_d = SEED;
          end

          if (word_in == pred_q) begin
            match_d = 1'b1;
            miss_d  = '0;
            if (run_q != RUN_W'(LOCK_MATCHES)) begin
              run_d = run_q + RUN_W'(1);
            end
            if (run_d == RUN_W'(LOCK_MATCHES)) begin
              locked_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
            run_d = '0;
            if (locked_q) begin
              if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
              end
              if (miss_inc >= MISS_W'(MISS_LIMIT)) begin
                locked_d = 1'b0;
                miss_d   = '0;
              end else begin
                // Flywheel: keep the locked prediction running past the bad word.
                miss_d    = miss_inc;
                run_d     = run_q;
                pred_d    = step(pred_q);
                adv_cnt_d = 5'd31;
                state_d   = ADVANCE;
              end
            end
          end
        end
      end

      default: state_d = SEED;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= SEED;
      pred_q       <= 32'd0;
      adv_cnt_q    <= 5'd0;
      run_q        <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      match_q      <= 1'b0;
      err_q        <= 1'b0;
      overrun_q    <= 1'b0;
      err_count_q  <= 16'd0;
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      pred_q       <= pred_d;
      adv_cnt_q    <= adv_cnt_d;
      run_q        <= run_d;
      miss_q       <= miss_d;
      locked_q     <= locked_d;
      match_q      <= match_d;
      err_q        <= err_d;
      overrun_q    <= overrun_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  assign locked        = locked_q;
  assign match_pulse   = match_q;
  assign err_pulse     = err_q;
  assign overrun_pulse = overrun_q;
  assign err_count     = err_count_q;
  assign word_count    = word_count_q;
  assign pred          = pred_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: seeding, lock acquisition, flywheel,
// lock loss, overrun, zero seeds and asynchronous reset.
module tb_lfsr_stream_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        word_valid;
  logic [31:0] word_in;
  logic        word_ready, locked, match_pulse, err_pulse, overrun_pulse;
  logic [15:0] err_count, word_count;
  logic [31:0] pred;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_cnt  = 0;
  logic [31:0] cur;
  logic [15:0] exp_wc;

  lfsr_stream_checker #(.LOCK_MATCHES(4), .MISS_LIMIT(3)) dut (
    .clock(clock), .reset(reset), .word_valid(word_valid), .word_in(word_in),
    .word_ready(word_ready), .locked(locked), .match_pulse(match_pulse),
    .err_pulse(err_pulse), .overrun_pulse(overrun_pulse), .err_count(err_count),
    .word_count(word_count), .pred(pred)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (overrun_pulse === 1'b1) ovr_cnt++;

  function automatic logic [31:0] step_f(input logic [31:0] s);
    return {s[31] ^ s[21] ^ s[1] ^ s[0], s[31:1]};
  endfunction

  function automatic logic [31:0] step32_f(input logic [31:0] s);
    logic [31:0] t = s;
    for (int i = 0; i < 32; i++) t = step_f(t);
    return t;
  endfunction

  // Presents a word for one edge from a falling edge; returns one falling edge later.
  task automatic put_word(input logic [31:0] w);
    word_valid = 1'b1;
    word_in    = w;
    @(negedge clock);
    word_valid = 1'b0;
    $display("word 0x%08h: match=%0b err=%0b locked=%0b wc=%0d ec=%0d pred=0x%08h",
             w, match_pulse, err_pulse, locked, word_count, err_count, pred);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({locked, match_pulse, err_pulse, overrun_pulse} !== 4'b0 ||
        pred !== 32'd0 || err_count !== 16'd0 || word_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: locked=%0b pulses=%0b%0b%0b pred=0x%08h ec=%0d wc=%0d, want all 0",
               locked, match_pulse, err_pulse, overrun_pulse, pred, err_count, word_count);
    end
  endtask

  task automatic test_stream();
    logic bad;
    do_reset();
    cur = 32'd13;
    exp_wc = 16'd1;
    put_word(cur);
    n_checks++;
    if (pred !== 32'h80000006) begin
      n_fail++; $display("FAIL seed_pred: got 0x%08h want 0x80000006", pred);
    end
    n_checks++;
    if (word_count !== exp_wc || word_ready !== 1'b0 || match_pulse !== 1'b0 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_state: wc=%0d ready=%0b m=%0b e=%0b want wc=1 ready=0 m=0 e=0",
               word_count, word_ready, match_pulse, err_pulse);
    end
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (word_ready !== 1'b0) bad = 1'b1;
    end
    @(negedge clock);
    n_checks++;
    if (bad || word_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_window: early_high=%0b ready_at_32=%0b want 0/1", bad, word_ready);
    end
    for (int i = 1; i <= 5; i++) begin
      cur = step32_f(cur);
      exp_wc++;
      put_word(cur);
      n_checks++;
      if (match_pulse !== 1'b1 || err_pulse !== 1'b0 || locked !== (i >= 4)) begin
        n_fail++;
        $display("FAIL stream_word%0d: m=%0b e=%0b locked=%0b want m=1 e=0 locked=%0b",
                 i, match_pulse, err_pulse, locked, (i >= 4));
      end
      repeat (31) @(negedge clock);
    end
    n_checks++;
    if (word_count !== exp_wc || err_count !== 16'd0 || ovr_cnt != 0) begin
      n_fail++;
      $display("FAIL stream_totals: wc=%0d ec=%0d ovr=%0d want wc=%0d ec=0 ovr=0",
               word_count, err_count, ovr_cnt, exp_wc);
    end
  endtask

  task automatic test_flywheel();
    cur = step32_f(cur);
    put_word(cur ^ 32'h1);
    n_checks++;
    if (err_pulse !== 1'b1 || match_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL fly_miss: e=%0b m=%0b ec=%0d locked=%0b want e=1 m=0 ec=1 locked=1",
               err_pulse, match_pulse, err_count, locked);
    end
    repeat (31) @(negedge clock);
    cur = step32_f(cur);
    put_word(cur);
    n_checks++;
    if (match_pulse !== 1'b1 || locked !== 1'b1 || err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL fly_recover: m=%0b locked=%0b ec=%0d want m=1 locked=1 ec=1",
               match_pulse, locked, err_count);
    end
    repeat (31) @(negedge clock);
  endtask

  task automatic test_lose_lock();
    logic [31:0] bad_w;
    bad_w = 32'd0;
    for (int j = 0; j < 3; j++) begin
      cur = step32_f(cur);
      bad_w = cur ^ 32'h1;
      put_word(bad_w);
      n_checks++;
      if (err_pulse !== 1'b1 || err_count !== 16'(2 + j) || locked !== (j < 2)) begin
        n_fail++;
        $display("FAIL lose_miss%0d: e=%0b ec=%0d locked=%0b want e=1 ec=%0d locked=%0b",
                 j, err_pulse, err_count, locked, 2 + j, (j < 2));
      end
      if (j < 2) repeat (31) @(negedge clock);
    end
    n_checks++;
    if (pred !== step_f(bad_w)) begin
      n_fail++; $display("FAIL lose_reseed: pred=0x%08h want 0x%08h", pred, step_f(bad_w));
    end
    repeat (31) @(negedge clock);
    cur = step32_f(bad_w);
    put_word(cur);
    n_checks++;
    if (match_pulse !== 1'b1 || locked !== 1'b0 || err_count !== 16'd4) begin
      n_fail++;
      $display("FAIL lose_relock: m=%0b locked=%0b ec=%0d want m=1 locked=0 ec=4",
               match_pulse, locked, err_count);
    end
    repeat (31) @(negedge clock);
  endtask

  task automatic test_overrun();
    logic [15:0] wc_snap;
    cur = step32_f(cur);
    put_word(cur);
    wc_snap = word_count;
    repeat (9) @(negedge clock);
    word_valid = 1'b1;
    word_in    = 32'hDEADBEEF;
    @(negedge clock);
    word_valid = 1'b0;
    $display("overrun word 0xdeadbeef: ovr=%0b wc=%0d", overrun_pulse, word_count);
    n_checks++;
    if (overrun_pulse !== 1'b1 || word_count !== wc_snap || match_pulse !== 1'b0 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun: ovr=%0b wc=%0d m=%0b e=%0b want ovr=1 wc=%0d m=0 e=0",
               overrun_pulse, word_count, match_pulse, err_pulse, wc_snap);
    end
    repeat (21) @(negedge clock);
    cur = step32_f(cur);
    put_word(cur);
    n_checks++;
    if (match_pulse !== 1'b1 || word_count !== wc_snap + 16'd1) begin
      n_fail++;
      $display("FAIL overrun_after: m=%0b wc=%0d want m=1 wc=%0d", match_pulse, word_count, wc_snap + 16'd1);
    end
  endtask

  task automatic test_seed_zero();
    do_reset();
    put_word(32'd0);
    n_checks++;
    if (word_count !== 16'd1 || word_ready !== 1'b1 || pred !== 32'd0 || match_pulse !== 1'b0 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_seed: wc=%0d ready=%0b pred=0x%08h m=%0b e=%0b want 1/1/0/0/0",
               word_count, word_ready, pred, match_pulse, err_pulse);
    end
    put_word(32'd0);
    put_word(32'd13);
    n_checks++;
    if (word_count !== 16'd3 || pred !== 32'h80000006 || word_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_then_seed: wc=%0d pred=0x%08h ready=%0b want 3/0x80000006/0",
               word_count, pred, word_ready);
    end
  endtask

  task automatic test_reset_mid_advance();
    do_reset();
    cur = 32'd13;
    put_word(cur);
    repeat (31) @(negedge clock);
    for (int i = 1; i <= 4; i++) begin
      cur = step32_f(cur);
      put_word(cur);
      if (i < 4) repeat (31) @(negedge clock);
    end
    n_checks++;
    if (locked !== 1'b1 || match_pulse !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_lock: locked=%0b m=%0b want 1/1", locked, match_pulse);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (locked !== 1'b0 || match_pulse !== 1'b0 || pred !== 32'd0 || word_count !== 16'd0 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: locked=%0b m=%0b pred=0x%08h wc=%0d ec=%0d want all 0",
               locked, match_pulse, pred, word_count, err_count);
    end
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if (word_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %0b want 1", word_ready);
    end
    put_word(32'd13);
    n_checks++;
    if (pred !== 32'h80000006 || word_count !== 16'd1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL reseed_after_reset: pred=0x%08h wc=%0d locked=%0b want 0x80000006/1/0",
               pred, word_count, locked);
    end
  endtask

  initial begin
    reset      = 1'b1;
    word_valid = 1'b0;
    word_in    = 32'd0;
    repeat (2) @(negedge clock);
    test_reset();
    test_stream();
    test_flywheel();
    test_lose_lock();
    test_overrun();
    test_seed_zero();
    test_reset_mid_advance();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
